// File: rtl/cv_gen_seq_pkg.sv
// cv_gen_seq_pkg: shared widths, position index type and the fixed 16-entry sequence table
package cv_gen_seq_pkg;
    localparam int SEQ_W     = 4;
    localparam int SEQ_DEPTH = 16;
    typedef logic [SEQ_W-1:0] idx_t;
    localparam idx_t TABLE [SEQ_DEPTH] = '{
        4'h3, 4'h7, 4'hB, 4'h1, 4'hE, 4'h5, 4'h9, 4'h0,
        4'hC, 4'h2, 4'h8, 4'hF, 4'h4, 4'hA, 4'h6, 4'hD
    };
endpackage

// File: rtl/cv_step_sync.sv
// cv_step_sync: SYNC_STAGES-deep STEP synchroniser with edge (EDGE_MODE=1) or level (0) event output; in clk rst_n step, out step_evt
module cv_step_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    output logic step_evt
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("cv_step_sync: SYNC_STAGES must be 2..4");
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], step};
            s_prev <= sync_q[SYNC_STAGES-1];
        end
    end
    assign step_evt = (EDGE_MODE != 0) ? (sync_q[SYNC_STAGES-1] & ~s_prev) : sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/cv_gen_seq.sv
// cv_gen_seq: 16-position sequence generator; in CLK RST(async low) STEP LOAD UP DAT_I[3:0], out SEQ[3:0]=TABLE[NOM] NOM[3:0]
module cv_gen_seq
    import cv_gen_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STEP,
    input  logic             LOAD,
    input  logic             UP,
    input  logic [SEQ_W-1:0] DAT_I,
    output logic [SEQ_W-1:0] SEQ,
    output logic [SEQ_W-1:0] NOM
);
    logic step_evt;
    cv_step_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE)) u_sync (
        .clk     (CLK),
        .rst_n   (RST),
        .step    (STEP),
        .step_evt(step_evt)
    );
    // LOAD wins over a coincident step event, which is dropped; 4-bit arithmetic gives the wrap
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) NOM <= '0;
        else      NOM <= LOAD ? DAT_I : step_evt ? (UP ? NOM + 1'b1 : NOM - 1'b1) : NOM;
    end
    assign SEQ = TABLE[NOM];
endmodule

// File: tb/tb_cv_gen_seq.sv
// tb_cv_gen_seq: scoreboard bench for cv_gen_seq with randomized steps/loads against a position model
module tb_cv_gen_seq;
    logic       CLK = 1'b0, RST = 1'b0, STEP = 1'b0, LOAD = 1'b0, UP = 1'b1;
    logic [3:0] DAT_I = 4'h0;
    logic [3:0] SEQ, NOM;
    cv_gen_seq #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut (
        .CLK(CLK), .RST(RST), .STEP(STEP), .LOAD(LOAD), .UP(UP),
        .DAT_I(DAT_I), .SEQ(SEQ), .NOM(NOM)
    );
    always #5 CLK = ~CLK;
    localparam logic [63:0] TB_TAB = 64'h37B1E590C28F4A6D;
    typedef struct {int at_edge; logic [3:0] nom; logic [3:0] seq;} exp_t;
    exp_t       q[$];
    int         cyc = 0, total = 0, bad = 0, model = 0;
    logic [3:0] mon_nom = 4'h0;
    always @(posedge CLK) cyc++;
    function automatic logic [3:0] tab(int i);
        return TB_TAB[60-4*(i%16) +: 4];
    endfunction
    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask
    task automatic tick(int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask
    // STEP first sampled at the next edge; the advance lands two edges after that
    task automatic step_pulse(bit up, int hi, int lo);
        UP = up;
        STEP = 1'b1;
        model = (model + (up ? 1 : 15)) % 16;
        q.push_back('{cyc + 3, 4'(model), tab(model)});
        tick(hi);
        STEP = 1'b0;
        tick(lo);
    endtask
    task automatic do_load(logic [3:0] v);
        LOAD = 1'b1;
        DAT_I = v;
        model = int'(v);
        q.push_back('{cyc + 1, v, tab(int'(v))});
        tick(1);
        LOAD = 1'b0;
        DAT_I = 4'($urandom);
        tick(1);
    endtask
    always @(negedge CLK) begin
        if (!RST) mon_nom = 4'h0;
        else begin
            while (q.size() != 0 && q[0].at_edge < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_event: got none want nom %h due at edge %0d", q[0].nom, q[0].at_edge);
                void'(q.pop_front());
            end
            if (q.size() != 0 && q[0].at_edge == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("nom_update", NOM, e.nom);
                chk("seq_update", SEQ, e.seq);
                mon_nom = e.nom;
            end else begin
                chk("nom_hold", NOM, mon_nom);
                chk("seq_hold", SEQ, tab(int'(mon_nom)));
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        #1;
        chk("reset_nom", NOM, 4'h0);
        chk("reset_seq", SEQ, 4'h3);
        repeat (3) begin
            STEP = 1'($urandom);
            LOAD = 1'b1;
            DAT_I = 4'($urandom);
            UP = 1'($urandom);
            #7;
            chk("reset_hold_nom", NOM, 4'h0);
            chk("reset_hold_seq", SEQ, 4'h3);
        end
        @(posedge CLK);
        #2;
        STEP = 1'b0;
        LOAD = 1'b0;
        RST = 1'b1;
        tick(3);
        repeat (16) step_pulse(1'b1, 4, 4);
        repeat (3) step_pulse(1'b0, 4, 4);
        do_load(4'h9);
        step_pulse(1'b1, 4, 4);
        UP = 1'b1;
        STEP = 1'b1;
        tick(2);
        LOAD = 1'b1;
        DAT_I = 4'((model + 5) % 16);
        model = (model + 5) % 16;
        q.push_back('{cyc + 1, 4'(model), tab(model)});
        tick(1);
        LOAD = 1'b0;
        tick(17);
        STEP = 1'b0;
        tick(4);
        step_pulse(1'b1, 20, 4);
        do_load(4'h6);
        UP = 1'b1;
        STEP = 1'b1;
        tick(1);
        RST = 1'b0;
        model = 0;
        #1;
        chk("midreset_nom", NOM, 4'h0);
        chk("midreset_seq", SEQ, 4'h3);
        STEP = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(5);
        step_pulse(1'b1, 4, 4);
        repeat (40) begin
            case ($urandom_range(0, 3))
                0, 1: step_pulse(1'($urandom), $urandom_range(1, 5), $urandom_range(2, 5));
                2: do_load(4'($urandom));
                default: tick($urandom_range(1, 4));
            endcase
        end
        tick(6);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cv_gen_seq.md
Name: cv_gen_seq

Overview:
- 16-position sequence generator.
- A 4-bit position counter (NOM) moves forward or backward through a fixed 16-entry table, one position per STEP event; SEQ is the table entry at the current position.
- NOM can be loaded directly from DAT_I.
- Used as a stimulus/pattern source driven by a slow external STEP strobe.

Parameters:
- SYNC_STAGES, 2: number of flip-flops synchronising STEP into the CLK domain (legal range 2..4).
- EDGE_MODE, 1: 1 = advance on each STEP rising edge; 0 = advance on every CLK cycle where synchronised STEP is high.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-low (RST=0 resets).
- STEP  input  1  advance strobe; may be asynchronous to CLK.
- LOAD  input  1  synchronous load of NOM from DAT_I.
- UP  input  1  direction: 1 = increment NOM, 0 = decrement NOM.
- DAT_I  input  4  load value for NOM.
- SEQ  output  4  sequence value = TABLE[NOM].
- NOM  output  4  current position index.

Behaviour:
- Reset (RST low, asynchronous):
  - NOM=0, so SEQ=TABLE[0]=4'h3.
  - All STEP synchroniser and edge flops cleared to 0.
  - Outputs hold while RST is low.
- TABLE, index 0..15, fixed: 3,7,B,1,E,5,9,0,C,2,8,F,4,A,6,D (hex). It is a permutation, so every value appears exactly once.
- SEQ:
  - Combinational decode of the registered NOM, so SEQ is always consistent with NOM in the same cycle.
  - No glitch requirement beyond that.
- STEP path:
  - STEP passes through SYNC_STAGES flops to give s_sync.
  - EDGE_MODE=1: step_evt = s_sync & ~s_prev, with s_prev registered.
  - EDGE_MODE=0: step_evt = s_sync.
- Latency: with SYNC_STAGES=2 and EDGE_MODE=1, if STEP is first sampled high at edge k, NOM changes at edge k+2. In general, NOM changes at edge k+SYNC_STAGES.
- Update priority on each rising CLK edge, highest first:
  - LOAD=1: NOM <= DAT_I. Any step_evt in the same cycle is discarded, not deferred.
  - step_evt=1 and UP=1: NOM <= NOM+1, wrapping 15 to 0.
  - step_evt=1 and UP=0: NOM <= NOM-1, wrapping 0 to 15.
  - Otherwise NOM holds.
- UP is sampled in the same cycle as step_evt. Changing UP between steps reverses direction starting at the next step.
- LOAD is level-sensitive: while it is held high, NOM tracks DAT_I every cycle.
- A STEP held high in EDGE_MODE=1 produces exactly one advance.
- Reset mid-operation clears any in-flight STEP edge; no advance occurs from a STEP edge that straddles reset.
- The synchroniser must not create a false edge immediately after reset release while STEP is low.

Decomposition:
- Shared package cv_gen_seq_pkg:
  - SEQ_W = 4
  - SEQ_DEPTH = 16
  - the constant TABLE array
  - an index typedef (4-bit)
- One natural sub-module, cv_step_sync: parameterised synchroniser plus edge/level detector that outputs step_evt.
- Counter, priority logic and table decode live in cv_gen_seq.

Test Plan:
- Reset: drive RST=0 with random inputs → NOM=0 and SEQ=4'h3 immediately (asynchronous), held until RST=1.
- Forward full cycle: UP=1, LOAD=0, 16 STEP pulses each 4 CLKs high / 4 low.
  - NOM goes 1,2,...,15,0.
  - SEQ follows 7,B,1,...,D,3.
  - Each NOM change occurs 2 edges after STEP is sampled high.
- Reverse with wrap: from NOM=0, UP=0, 3 STEP pulses → NOM=15,14,13 and SEQ=D,6,A.
- Load: DAT_I=4'h9, LOAD=1 for one cycle → NOM=9, SEQ=4'h2 on that edge. Then UP=1 and one STEP → NOM=10, SEQ=4'h8.
- Load/step collision: LOAD=1 in the same cycle step_evt fires → NOM=DAT_I with no extra increment. A STEP held high for 20 cycles in EDGE_MODE=1 → exactly one advance.
- Reset mid-operation: assert RST low 1 cycle after a STEP rising edge, release → NOM=0, no advance after release. The next STEP pulse → NOM=1 (UP=1).
